// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch requester (read-only) and the
// data requester (load/store). Round-robin arbitration, one transaction in flight,
// fixed read latency of RD_LAT cycles.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;
  typedef enum logic {OwnIf, OwnD} owner_e;

  state_e            state_q, state_d;
  owner_e            last_grant_q, last_grant_d;
  owner_e            owner_q, owner_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              grant_if, grant_d;

  // Round-robin grant, only while idle; on conflict the port not granted last wins.
  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (state_q == StIdle) begin
      if (if_req && d_req) begin
        if (last_grant_q == OwnD) grant_if = 1'b1;
        else                      grant_d  = 1'b1;
      end else if (if_req) begin
        grant_if = 1'b1;
      end else if (d_req) begin
        grant_d = 1'b1;
      end
    end
  end

  // Next-state and registered-output computation for the transaction FSM.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    // Pulses and write strobe default low so they can only last one cycle.
    mem_we_d     = 1'b0;
    if_rvalid_d  = 1'b0;
    d_rvalid_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_d) begin
          owner_d      = OwnD;
          last_grant_d = OwnD;
          mem_addr_d   = d_addr;
          if (d_we) begin
            mem_wdata_d = d_wdata;
            mem_we_d    = 1'b1;
            state_d     = StWrite;
          end else begin
            cnt_d   = 4'(RD_LAT);
            state_d = StRead;
          end
        end else if (grant_if) begin
          owner_d      = OwnIf;
          last_grant_d = OwnIf;
          mem_addr_d   = if_addr;
          cnt_d        = 4'(RD_LAT);
          state_d      = StRead;
        end
      end
      StRead: begin
        if (cnt_q == 4'd1) begin
          // Last read cycle: memory data is valid now, hand it to the owner.
          if (owner_q == OwnD) begin
            d_rdata_d  = mem_rdata;
            d_rvalid_d = 1'b1;
          end else begin
            if_rdata_d  = mem_rdata;
            if_rvalid_d = 1'b1;
          end
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StWrite: begin
        d_rvalid_d = 1'b1;
        state_d    = StResp;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and registered outputs; reset discards any in-flight transaction.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= StIdle;
      last_grant_q <= OwnIf;
      owner_q      <= OwnIf;
      cnt_q        <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      if_rvalid_q  <= 1'b0;
      d_rvalid_q   <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      if_rvalid_q  <= if_rvalid_d;
      d_rvalid_q   <= d_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign if_ready  = grant_if;
  assign d_ready   = grant_d;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: instance a uses RD_LAT=1, instance b uses RD_LAT=3; both share
// one word-addressed memory model (only instance a ever writes).
module tb_mem_port_arbiter;

  logic        Clk;
  logic        Reset;

  logic        if_req, if_ready, if_rvalid, d_req, d_we, d_ready, d_rvalid, mem_we, busy;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        b_if_req, b_if_ready, b_if_rvalid, b_d_req, b_d_we, b_d_ready, b_d_rvalid;
  logic        b_mem_we, b_busy;
  logic [31:0] b_if_addr, b_if_rdata, b_d_addr, b_d_wdata, b_d_rdata, b_mem_addr, b_mem_wdata;
  logic [31:0] b_mem_rdata;

  logic [31:0] mem [0:255];
  int          n_checks;
  int          n_fail;
  int          we_cnt;
  int          b_we_cnt;
  logic [31:0] we_addr;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) dut_a (
    .Clk(Clk), .Reset(Reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(d_ready),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3)) dut_b (
    .Clk(Clk), .Reset(Reset),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_ready(b_if_ready), .if_rvalid(b_if_rvalid),
    .if_rdata(b_if_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_ready(b_d_ready), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we),
    .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  assign mem_rdata   = mem[mem_addr[9:2]];
  assign b_mem_rdata = mem[b_mem_addr[9:2]];

  always @(posedge Clk) begin
    if (mem_we === 1'b1) mem[mem_addr[9:2]] <= mem_wdata;
  end

  always @(negedge Clk) begin
    if (mem_we === 1'b1) begin
      we_cnt  = we_cnt + 1;
      we_addr = mem_addr;
    end
    if (b_mem_we === 1'b1) b_we_cnt = b_we_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    n_checks = 0; n_fail = 0; we_cnt = 0; b_we_cnt = 0; we_addr = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h04] = 32'h8C02_0004;  // byte address 0x10
    mem[8'h10] = 32'h1234_5678;  // byte address 0x40
    Reset = 1'b1;
    if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    b_if_req = 0; b_if_addr = '0; b_d_req = 0; b_d_we = 0; b_d_addr = '0; b_d_wdata = '0;
    tick(); tick();
    Reset = 1'b0;
    #1;
    // Reset state
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
    chk("rst_ready_noreq", {30'd0, if_ready, d_ready}, 32'd0);

    // 1: fetch of 0x10, RD_LAT=1
    tick();
    if_req = 1; if_addr = 32'h10;
    #1;
    chk("t1_ready_T", {30'd0, if_ready, d_ready}, 32'd2);
    tick();  // T+1
    if_req = 0; if_addr = 32'hFFFF_FFF0;
    #1;
    chk("t1_busy_T1", {31'd0, busy}, 32'd1);
    chk("t1_mem_addr_T1", mem_addr, 32'h10);
    chk("t1_rvalid_T1", {31'd0, if_rvalid}, 32'd0);
    tick();  // T+2
    chk("t1_rvalid_T2", {31'd0, if_rvalid}, 32'd1);
    chk("t1_rdata_T2", if_rdata, 32'h8C02_0004);
    tick();  // T+3
    chk("t1_rvalid_T3", {31'd0, if_rvalid}, 32'd0);
    chk("t1_idle_T3", {31'd0, busy}, 32'd0);
    chk("t1_we_cnt", 32'(we_cnt), 32'd0);

    // 2: store 0xDEADBEEF to 0x20, then load it back
    d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF;
    #1;
    chk("t2_ready_T", {30'd0, if_ready, d_ready}, 32'd1);
    chk("t2_we_T", {31'd0, mem_we}, 32'd0);
    tick();  // T+1
    d_req = 0; d_we = 0; d_wdata = '0;
    #1;
    chk("t2_we_T1", {31'd0, mem_we}, 32'd1);
    chk("t2_addr_T1", mem_addr, 32'h20);
    chk("t2_wdata_T1", mem_wdata, 32'hDEAD_BEEF);
    chk("t2_rvalid_T1", {31'd0, d_rvalid}, 32'd0);
    tick();  // T+2
    chk("t2_we_T2", {31'd0, mem_we}, 32'd0);
    chk("t2_rvalid_T2", {31'd0, d_rvalid}, 32'd1);
    chk("t2_rdata_unchanged", d_rdata, 32'd0);
    tick();  // T+3
    chk("t2_we_cnt", 32'(we_cnt), 32'd1);
    chk("t2_we_addr", we_addr, 32'h20);
    d_req = 1; d_we = 0; d_addr = 32'h20;
    #1;
    chk("t2_ld_ready", {31'd0, d_ready}, 32'd1);
    tick();
    d_req = 0;
    tick();
    chk("t2_ld_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("t2_ld_rdata", d_rdata, 32'hDEAD_BEEF);
    chk("t2_ld_if_rdata_kept", if_rdata, 32'h8C02_0004);
    tick();

    // 3: both requesters held from reset -> D, IF, D, IF, three cycles apart
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    if_req = 1; if_addr = 32'h10; d_req = 1; d_we = 0; d_addr = 32'h40;
    #1;
    for (int k = 0; k < 4; k++) begin
      c = 0;
      while (!(if_ready || d_ready) && c < 8) begin
        tick();
        c = c + 1;
      end
      chk($sformatf("t3_grant%0d", k), {30'd0, if_ready, d_ready},
          (k % 2 == 0) ? 32'd1 : 32'd2);
      chk($sformatf("t3_wait%0d", k), 32'(c), (k == 0) ? 32'd0 : 32'd2);
      tick();
    end
    if_req = 0; d_req = 0;
    tick(); tick();
    chk("t3_d_rdata", d_rdata, 32'h1234_5678);
    chk("t3_if_rdata", if_rdata, 32'h8C02_0004);
    chk("t3_we_cnt", 32'(we_cnt), 32'd1);

    // 4: RD_LAT=3 load of 0x40 with request held while busy
    b_d_req = 1; b_d_we = 0; b_d_addr = 32'h40;
    #1;
    chk("t4_ready_T", {31'd0, b_d_ready}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("t4_busy_T%0d", i), {31'd0, b_busy}, 32'd1);
      chk($sformatf("t4_ready_T%0d", i), {31'd0, b_d_ready}, 32'd0);
      chk($sformatf("t4_rvalid_T%0d", i), {31'd0, b_d_rvalid}, (i == 4) ? 32'd1 : 32'd0);
    end
    tick();  // T+5
    chk("t4_idle_T5", {31'd0, b_busy}, 32'd0);
    chk("t4_reaccept_T5", {31'd0, b_d_ready}, 32'd1);
    chk("t4_rdata", b_d_rdata, 32'h1234_5678);
    b_d_req = 0;
    #1;
    chk("t4_withdrawn", {31'd0, b_d_ready}, 32'd0);
    tick();
    chk("t4_no_txn", {31'd0, b_busy}, 32'd0);

    // 5: reset during WRITE (a) and READ (b)
    d_req = 1; d_we = 1; d_addr = 32'h80; d_wdata = 32'h0000_0055;
    b_d_req = 1; b_d_addr = 32'h10;
    #1;
    tick();
    d_req = 0; d_we = 0; b_d_req = 0;
    #1;
    chk("t5_we_before", {31'd0, mem_we}, 32'd1);
    Reset = 1'b1;
    #1;
    chk("t5_we_async", {31'd0, mem_we}, 32'd0);
    chk("t5_busy_a", {31'd0, busy}, 32'd0);
    chk("t5_busy_b", {31'd0, b_busy}, 32'd0);
    chk("t5_addr_a", mem_addr, 32'd0);
    chk("t5_rdata_a", d_rdata, 32'd0);
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t5_no_rvalid%0d", i), {30'd0, d_rvalid, b_d_rvalid}, 32'd0);
    end
    chk("t5_we_cnt", 32'(we_cnt), 32'd1);
    chk("t5_b_we_cnt", 32'(b_we_cnt), 32'd0);
    d_req = 1; d_we = 0; d_addr = 32'h80;
    #1;
    chk("t5_reissue_ready", {31'd0, d_ready}, 32'd1);
    tick();
    d_req = 0;
    tick();
    chk("t5_reissue_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("t5_not_written", d_rdata, 32'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
